// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit with HI/LO registers
// Ports:
//   clk, reset (async, active-low)
//   start, op[2:0]  : op 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd
//   a, b [31:0]     : forwarded rs / rt operands
//   rd_sel          : 0 reads LO, 1 reads HI on rd_data
//   busy            : multi-cycle operation in flight
//   hi, lo, rd_data : HI/LO registers and combinational read port
// Define MDU_MADD_EN to make op 7 a signed multiply-accumulate into {hi,lo};
// otherwise op 7 is a no-op and no accumulate adder exists.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pending_hi, pending_lo;
  logic        div0;
  logic [63:0] prod_s, prod_u, madd_res, res;
  logic [31:0] dividend, divisor, q_mag, r_mag, quot, rem;
  logic        is_sdiv, is_div, is_madd, is_long;
`ifdef MDU_MADD_EN
  assign is_madd  = op == 3'd7;
  assign madd_res = {hi, lo} + prod_s;
`else
  assign is_madd  = 1'b0;
  assign madd_res = '0;
`endif
  assign is_sdiv = op == 3'd3;
  assign is_div  = op == 3'd3 || op == 3'd4;
  assign is_long = op == 3'd1 || op == 3'd2 || is_div || is_madd;
  assign rd_data = rd_sel ? hi : lo;
  // Signed divide runs on magnitudes so 0x80000000 / -1 falls out naturally
  // as 0x80000000 with remainder 0; a zero divisor is forced to 1 to keep the
  // divider defined, its result is discarded via div0.
  always_comb begin
    prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u   = {32'b0, a} * {32'b0, b};
    dividend = is_sdiv && a[31] ? -a : a;
    divisor  = b == 32'd0 ? 32'd1 : (is_sdiv && b[31] ? -b : b);
    q_mag    = dividend / divisor;
    r_mag    = dividend % divisor;
    quot     = is_sdiv && (a[31] ^ b[31]) ? -q_mag : q_mag;
    rem      = is_sdiv && a[31] ? -r_mag : r_mag;
    res      = op == 3'd1 ? prod_s :
               op == 3'd2 ? prod_u :
               is_madd    ? madd_res : {rem, quot};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
      div0       <= 1'b0;
    end else if (state == IDLE) begin
      if (start && is_long) begin
        pending_hi <= res[63:32];
        pending_lo <= res[31:0];
        div0       <= is_div && b == 32'd0;
        cnt        <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        busy       <= 1'b1;
        state      <= RUN;
      end else if (start && op == 3'd5) begin
        hi <= a;
      end else if (start && op == 3'd6) begin
        lo <= a;
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        if (!div0) begin
          hi <= pending_hi;
          lo <= pending_lo;
        end
        busy  <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
  logic        clk = 0, reset = 1, start = 0, rd_sel = 0;
  logic [2:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy;
  logic [31:0] hi, lo, rd_data;
  int vectors = 0, miscompares = 0;

  md_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
               .rd_sel(rd_sel), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data));

  always #5 clk = ~clk;

  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0; op = 0;
  endtask

  task automatic count_busy(output int n, output logic moved);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; n = 0; moved = 0;
    while (busy && n < 40) begin
      if (hi !== h0 || lo !== l0) moved = 1;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #3 reset = 0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_mult;
    int n; logic m;
    start_op(3'd1, 32'hFFFFFFFF, 32'd2);
    count_busy(n, m);
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL mult_busy: got %0d cycles want 5", n); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    vectors++; if (lo !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_multu;
    int n; logic m;
    start_op(3'd2, 32'hFFFFFFFF, 32'd2);
    count_busy(n, m);
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL multu_busy: got %0d cycles want 5", n); end
    vectors++; if (m !== 1'b0) begin miscompares++; $display("FAIL multu_early_write: got changed=%b want 0", m); end
    vectors++; if (hi !== 32'h00000001) begin miscompares++; $display("FAIL multu_hi: got %h want 00000001", hi); end
    vectors++; if (lo !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_div;
    int n; logic m;
    start_op(3'd3, 32'hFFFFFFF9, 32'd2);
    count_busy(n, m);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL div_busy: got %0d cycles want 10", n); end
    vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    start_op(3'd4, 32'hFFFFFFF9, 32'd2);
    count_busy(n, m);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL divu_busy: got %0d cycles want 10", n); end
    vectors++; if (lo !== 32'h7FFFFFFC) begin miscompares++; $display("FAIL divu_lo: got %h want 7ffffffc", lo); end
    vectors++; if (hi !== 32'h00000001) begin miscompares++; $display("FAIL divu_hi: got %h want 00000001", hi); end
    start_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n, m);
    vectors++; if (lo !== 32'h80000000) begin miscompares++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
    start_op(3'd3, 32'd100, 32'hFFFFFFF9);
    count_busy(n, m);
    vectors++; if (lo !== 32'hFFFFFFF2) begin miscompares++; $display("FAIL div_negb_lo: got %h want fffffff2", lo); end
    vectors++; if (hi !== 32'h00000002) begin miscompares++; $display("FAIL div_negb_hi: got %h want 00000002", hi); end
  endtask

  task automatic test_move_div0;
    int n; logic m;
    start_op(3'd5, 32'h12345678, 32'd0);
    vectors++; if (hi !== 32'h12345678) begin miscompares++; $display("FAIL mthi: got %h want 12345678", hi); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy: got %b want 0", busy); end
    start_op(3'd6, 32'h9ABCDEF0, 32'd0);
    vectors++; if (lo !== 32'h9ABCDEF0) begin miscompares++; $display("FAIL mtlo: got %h want 9abcdef0", lo); end
    start_op(3'd3, 32'd55, 32'd0);
    count_busy(n, m);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL div0_busy: got %0d cycles want 10", n); end
    rd_sel = 1; #1;
    vectors++; if (rd_data !== 32'h12345678) begin miscompares++; $display("FAIL div0_rd_hi: got %h want 12345678", rd_data); end
    rd_sel = 0; #1;
    vectors++; if (rd_data !== 32'h9ABCDEF0) begin miscompares++; $display("FAIL div0_rd_lo: got %h want 9abcdef0", rd_data); end
    start_op(3'd0, 32'h55555555, 32'd3);
    vectors++; if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      miscompares++; $display("FAIL op0_noop: got busy=%b hi=%h lo=%h want 0/12345678/9abcdef0", busy, hi, lo);
    end
  endtask

  task automatic test_reset_midop;
    start_op(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midop_busy: got %b want 1", busy); end
    #1 reset = 0;
    #1;
    vectors++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++; $display("FAIL midop_reset: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk); reset = 1;
    repeat (15) @(negedge clk);
    vectors++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++; $display("FAIL midop_late_wb: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_start_while_busy;
    int n; logic m;
    start_op(3'd1, 32'd3, 32'd4);
    @(negedge clk);
    start = 1; op = 3'd1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 0; op = 0;
    count_busy(n, m);
    vectors++; if (n + 2 !== 5) begin miscompares++; $display("FAIL ignore_busy: got %0d cycles want 5", n + 2); end
    vectors++; if (lo !== 32'd12 || hi !== 32'd0) begin miscompares++; $display("FAIL ignore_result: got hi=%h lo=%h want 00000000/0000000c", hi, lo); end
  endtask

  task automatic test_madd;
    int n; logic m;
    start_op(3'd5, 32'h0, 32'd0);
    start_op(3'd6, 32'hFFFFFFFF, 32'd0);
    start_op(3'd7, 32'd1, 32'd1);
    count_busy(n, m);
`ifdef MDU_MADD_EN
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL madd_busy: got %0d cycles want 5", n); end
    vectors++; if (hi !== 32'h1 || lo !== 32'h0) begin miscompares++; $display("FAIL madd_result: got hi=%h lo=%h want 00000001/00000000", hi, lo); end
`else
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL madd_off_busy: got %0d cycles want 0", n); end
    vectors++; if (hi !== 32'h0 || lo !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL madd_off_result: got hi=%h lo=%h want 00000000/ffffffff", hi, lo); end
`endif
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_move_div0;
    test_reset_midop;
    test_start_while_busy;
    test_madd;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
